// File: rtl/pkt_framer.sv
// ---------------------------------------------------------------------------
// pkt_framer
//   Wraps a run of payload words into a framed packet: one header word,
//   exactly `len` payload words pulled from a valid/ready source, then one
//   tail word. Back-to-back packets are supported: a start seen during the
//   tail cycle launches the next header on the very next cycle.
//
// Optional feature macro: PKT_FRAMER_CHKSUM_EN
//   defined   -> the tail word carries the XOR of all payload words
//                (0 for an empty packet).
//   undefined -> the tail word is 0 and no checksum register exists.
//
// Ports
//   reset_n   in   1        async active-low reset
//   clk       in   1        rising-edge clock
//   start     in   1        packet request (honoured in IDLE and TAIL)
//   len       in   LEN_W    payload word count, captured with start
//   hdr       in   DATA_W   header word, captured with start
//   src_valid in   1        payload source has a word
//   src_data  in   DATA_W   payload word
//   src_ready out  1        payload word is accepted this cycle (comb)
//   valid     out  1        output word valid (registered)
//   head      out  1        output word is the header (registered)
//   tail      out  1        output word is the tail (registered)
//   data      out  DATA_W   output word (registered)
//   busy      out  1        framer is not idle
// ---------------------------------------------------------------------------
module pkt_framer #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              reset_n,
    input  logic              clk,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] hdr,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              valid,
    output logic              head,
    output logic              tail,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    // The state names the type of word currently on the output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAD = 2'b01,
        DATA = 2'b10,
        TAIL = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic                valid_q, valid_d;
    logic                head_q,  head_d;
    logic                tail_q,  tail_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [DATA_W-1:0]   tail_word;
    logic                in_body;
    logic                cnt_nz;

`ifdef PKT_FRAMER_CHKSUM_EN
    logic [DATA_W-1:0]   chk_q, chk_d;
    assign tail_word = chk_q;
`else
    assign tail_word = '0;
`endif

    // HEAD and DATA both pull payload; the header cycle already counts as
    // a pull opportunity, so a ready source streams with no bubble.
    assign in_body   = (state_q == HEAD) || (state_q == DATA);
    assign cnt_nz    = (count_q != '0);
    assign src_ready = in_body && cnt_nz;

    assign valid = valid_q;
    assign head  = head_q;
    assign tail  = tail_q;
    assign data  = data_q;
    assign busy  = (state_q != IDLE);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            valid_q <= 1'b0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            data_q  <= data_d;
        end
    end

`ifdef PKT_FRAMER_CHKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        valid_d = 1'b0;
        head_d  = 1'b0;
        tail_d  = 1'b0;
        data_d  = data_q;      // data holds through gaps and idle
`ifdef PKT_FRAMER_CHKSUM_EN
        chk_d   = chk_q;
`endif

        unique case (state_q)
            IDLE, TAIL: begin
                // TAIL behaves like IDLE for start so packets can abut.
                if (start) begin
                    state_d = HEAD;
                    count_d = len;
                    valid_d = 1'b1;
                    head_d  = 1'b1;
                    data_d  = hdr;
`ifdef PKT_FRAMER_CHKSUM_EN
                    chk_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end

            HEAD, DATA: begin
                // start is deliberately not looked at here.
                if (!cnt_nz) begin
                    // All payload taken (or none requested): emit tail.
                    state_d = TAIL;
                    valid_d = 1'b1;
                    tail_d  = 1'b1;
                    data_d  = tail_word;
                end else if (src_valid) begin
                    state_d = DATA;
                    count_d = count_q - LEN_W'(1);
                    valid_d = 1'b1;
                    data_d  = src_data;
`ifdef PKT_FRAMER_CHKSUM_EN
                    chk_d   = chk_q ^ src_data;
`endif
                end else begin
                    // Source stalled: bubble on the output, data holds.
                    state_d = DATA;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pkt_framer.sv
module tb_pkt_framer;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    logic              reset_n;
    logic              clk;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] hdr;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              valid;
    logic              head;
    logic              tail;
    logic [DATA_W-1:0] data;
    logic              busy;

    pkt_framer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .reset_n   (reset_n),
        .clk       (clk),
        .start     (start),
        .len       (len),
        .hdr       (hdr),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .valid     (valid),
        .head      (head),
        .tail      (tail),
        .data      (data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard entry: {head, tail, data}
    logic [DATA_W+1:0] sb[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W+1:0] w(input logic h, input logic t, input logic [DATA_W-1:0] d);
        return {h, t, d};
    endfunction

    function automatic logic [DATA_W-1:0] tailw(input logic [DATA_W-1:0] x);
`ifdef PKT_FRAMER_CHKSUM_EN
        return x;
`else
        return (x & 8'h00);
`endif
    endfunction

    // Advance one clock; sample 1 time unit after the edge and retire any
    // valid output word against the scoreboard.
    task automatic tick();
        logic [DATA_W+1:0] e;
        @(posedge clk);
        #1;
        chk("head_tail_excl", {31'd0, head & tail}, 32'd0);
        if (!valid) begin
            chk("flags_need_valid", {30'd0, head, tail}, 32'd0);
        end else if (sb.size() == 0) begin
            chk("unexpected_word", {22'd0, head, tail, data}, 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            chk("word", {22'd0, head, tail, data}, {22'd0, e});
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        len       = '0;
        hdr       = '0;
        src_valid = 1'b0;
        src_data  = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, src_ready}, 32'd0);
        reset_n = 1'b1;

        // ---------------- len=3 streaming packet ----------------
        start = 1'b1; len = 4'd3; hdr = 8'hA5; src_valid = 1'b1; src_data = 8'h01;
        sb.push_back(w(1'b1, 1'b0, 8'hA5));
        tick();
        chk("p1_v0", {31'd0, valid}, 32'd1);
        chk("p1_busy", {31'd0, busy}, 32'd1);
        chk("p1_ready_head", {31'd0, src_ready}, 32'd1);
        start = 1'b0;
        sb.push_back(w(1'b0, 1'b0, 8'h01));
        tick();
        chk("p1_v1", {31'd0, valid}, 32'd1);
        src_data = 8'h02;
        sb.push_back(w(1'b0, 1'b0, 8'h02));
        tick();
        chk("p1_v2", {31'd0, valid}, 32'd1);
        src_data = 8'h04;
        sb.push_back(w(1'b0, 1'b0, 8'h04));
        tick();
        chk("p1_v3", {31'd0, valid}, 32'd1);
        chk("p1_ready_done", {31'd0, src_ready}, 32'd0);
        src_valid = 1'b0;
        sb.push_back(w(1'b0, 1'b1, tailw(8'h07)));
        tick();
        chk("p1_v4", {31'd0, valid}, 32'd1);
        tick();
        chk("p1_idle_valid", {31'd0, valid}, 32'd0);
        chk("p1_idle_busy", {31'd0, busy}, 32'd0);

        // ---------------- len=0: head then tail, source ignored ----------------
        start = 1'b1; len = 4'd0; hdr = 8'h3C; src_valid = 1'b1; src_data = 8'hEE;
        sb.push_back(w(1'b1, 1'b0, 8'h3C));
        tick();
        start = 1'b0;
        chk("z_ready_head", {31'd0, src_ready}, 32'd0);
        sb.push_back(w(1'b0, 1'b1, 8'h00));
        tick();
        chk("z_tail", {31'd0, tail}, 32'd1);
        chk("z_ready_tail", {31'd0, src_ready}, 32'd0);
        src_valid = 1'b0;
        tick();
        chk("z_busy", {31'd0, busy}, 32'd0);

        // ---------------- len=2 with a 2-cycle source gap ----------------
        start = 1'b1; len = 4'd2; hdr = 8'h11;
        sb.push_back(w(1'b1, 1'b0, 8'h11));
        tick();
        start = 1'b0; src_valid = 1'b1; src_data = 8'hAA;
        sb.push_back(w(1'b0, 1'b0, 8'hAA));
        tick();
        src_valid = 1'b0;
        tick();
        chk("g_gap1_valid", {31'd0, valid}, 32'd0);
        chk("g_gap1_hold", {24'd0, data}, 32'hAA);
        chk("g_gap1_ready", {31'd0, src_ready}, 32'd1);
        tick();
        chk("g_gap2_valid", {31'd0, valid}, 32'd0);
        chk("g_gap2_busy", {31'd0, busy}, 32'd1);
        src_valid = 1'b1; src_data = 8'h55;
        sb.push_back(w(1'b0, 1'b0, 8'h55));
        tick();
        chk("g_w2_tail", {31'd0, tail}, 32'd0);
        src_valid = 1'b0;
        sb.push_back(w(1'b0, 1'b1, tailw(8'hFF)));
        tick();
        chk("g_tail", {31'd0, tail}, 32'd1);

        // ---------------- start during tail: back-to-back ----------------
        start = 1'b1; len = 4'd1; hdr = 8'h5A;
        sb.push_back(w(1'b1, 1'b0, 8'h5A));
        tick();
        chk("b_head", {31'd0, head}, 32'd1);
        chk("b_busy", {31'd0, busy}, 32'd1);
        // start (with a different header) stays high through HEAD/DATA
        hdr = 8'h99; len = 4'd5; src_valid = 1'b1; src_data = 8'h33;
        sb.push_back(w(1'b0, 1'b0, 8'h33));
        tick();
        src_valid = 1'b0;
        sb.push_back(w(1'b0, 1'b1, tailw(8'h33)));
        tick();
        chk("b_tail", {31'd0, tail}, 32'd1);
        start = 1'b0;
        tick();
        chk("b_idle", {31'd0, busy}, 32'd0);

        // ---------------- reset mid-packet ----------------
        start = 1'b1; len = 4'd4; hdr = 8'hC3; src_valid = 1'b1; src_data = 8'h01;
        sb.push_back(w(1'b1, 1'b0, 8'hC3));
        tick();
        start = 1'b0;
        sb.push_back(w(1'b0, 1'b0, 8'h01));
        tick();
        src_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("r_async_valid", {31'd0, valid}, 32'd0);
        chk("r_async_data", {24'd0, data}, 32'd0);
        chk("r_async_busy", {31'd0, busy}, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r_no_tail", {30'd0, valid, tail}, 32'd0);
        end
        chk("r_busy", {31'd0, busy}, 32'd0);

        // normal packet after reset
        start = 1'b1; len = 4'd1; hdr = 8'h77; src_valid = 1'b1; src_data = 8'h0F;
        sb.push_back(w(1'b1, 1'b0, 8'h77));
        tick();
        start = 1'b0;
        sb.push_back(w(1'b0, 1'b0, 8'h0F));
        tick();
        src_valid = 1'b0;
        sb.push_back(w(1'b0, 1'b1, tailw(8'h0F)));
        tick();
        tick();
        chk("n_idle", {31'd0, busy}, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pkt_framer.md
PKT_FRAMER -- requirements
Module: pkt_framer

Interface
REQ-001 Parameter DATA_W, default 8, width of header, payload and tail words.
REQ-002 Parameter LEN_W, default 4, width of payload length field; max payload 2^LEN_W-1 words.
REQ-003 The interface SHALL have one clock, clk, and an asynchronous, active-low reset, reset_n, declared first among the ports.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  packet request, sampled on a rising clk edge.
REQ-007 len  input  LEN_W  payload word count, captured with start.
REQ-008 hdr  input  DATA_W  header word, captured with start.
REQ-009 src_valid  input  1  payload source has a word.
REQ-010 src_data  input  DATA_W  payload word.
REQ-011 src_ready  output  1  framer accepts payload this cycle; combinational from state and count.
REQ-012 valid  output  1  registered; output word is valid.
REQ-013 head  output  1  registered; output word is a header.
REQ-014 tail  output  1  registered; output word is a tail.
REQ-015 data  output  DATA_W  registered output word.
REQ-016 busy  output  1  state != IDLE.

Function
REQ-017 FSM states SHALL be IDLE=2'b00, HEAD=2'b01, DATA=2'b10, TAIL=2'b11; the state names the word type currently driven.
REQ-018 In IDLE, an edge with start=1 SHALL load valid=1, head=1, tail=0, data=hdr, count=len, checksum=0, go to HEAD; start-to-head latency is 1 cycle.
REQ-019 start SHALL be ignored in HEAD and DATA.
REQ-020 src_ready SHALL equal (state==HEAD or state==DATA) and count!=0.
REQ-021 In HEAD or DATA, an edge with src_valid and src_ready SHALL load valid=1, head=0, tail=0, data=src_data, decrement count, XOR src_data into checksum, go to DATA.
REQ-022 In HEAD or DATA with count!=0 and src_valid=0, the edge SHALL load valid=0 (gap cycle); data holds; state goes to or stays in DATA.
REQ-023 In HEAD or DATA with count==0, the edge SHALL load valid=1, tail=1, head=0, data=tail word, go to TAIL.
REQ-024 len=0 SHALL produce HEAD immediately followed by TAIL, no DATA words, src_ready never asserted.
REQ-025 In TAIL, start=1 SHALL load a new header exactly as in REQ-018 (back-to-back, no idle cycle); else valid=head=tail=0, go to IDLE.
REQ-026 head and tail SHALL never be 1 together; each is 1 only with valid=1.
REQ-027 Exactly len payload words SHALL be accepted per packet; src_valid while src_ready=0 SHALL not be consumed.

Reset
REQ-028 reset_n low SHALL asynchronously force state=IDLE, valid=head=tail=0, data=0, count=0, checksum=0.
REQ-029 Reset mid-packet SHALL drop the packet; no tail is emitted after release.
REQ-030 First start is honoured on the first rising edge with reset_n high.

Configuration
REQ-031 Macro PKT_FRAMER_CHKSUM_EN: defined -> tail word is XOR of all payload words of the packet (0 when len=0); undefined -> tail word is 0 and no checksum register is built.

Verification
REQ-032 Reset, start, len=3, hdr=8'hA5, src_valid held 1 with 8'h01,8'h02,8'h04 -> valid words A5(head),01,02,04,tail 07 (CHKSUM_EN) or 00, on 5 consecutive cycles.
REQ-033 len=0, hdr=8'h3C -> head 3C then tail 00 next cycle; src_ready stays 0; busy drops after tail.
REQ-034 len=2, src_valid low for 2 cycles between words -> 2 gap cycles with valid=0, state DATA, tail only after second word.
REQ-035 start asserted during tail cycle with hdr=8'h5A -> head 5A on the cycle after tail, no IDLE cycle; start during DATA ignored.
REQ-036 reset_n pulsed low after 1 of 4 payload words -> outputs 0 immediately, IDLE after release, no tail observed; next start frames normally.
